// File: rtl/byte_un_striping_p.sv
// -----------------------------------------------------------------------------
// byte_un_striping_p
//
// Merges LANES parallel lanes of WIDTH-bit words back into one stream in the
// fast (n x f) clock domain. The block waits in IDLE for a valid word on
// lane 0. It then collects one lane per cycle in round-robin order. After
// GAP_LIMIT consecutive rounds with no valid slot, it falls back to IDLE and
// re-aligns on lane 0. All outputs are registered, with 1 cycle of latency.
//
// Optional build macro:
//   UNSTRIPE_GAP_CNT_EN  enables the saturating invalid-slot counter on
//                        gap_count. When undefined, gap_count is tied to 0.
//
// Ports:
//   clk_nf       in   fast clock, one slot per lane per round
//   reset        in   asynchronous active-low reset
//   valid_in     in   [LANES]        per-lane valid, bit k is lane k
//   lane_in      in   [LANES*WIDTH]  lane k at [k*WIDTH +: WIDTH]
//   valid_out_c  out  merged word valid
//   data_out_c   out  [WIDTH]        merged word (0 when not valid)
//   lane_sel     out  [clog2(LANES)] lane the current output came from
//   aligned      out  high while collecting (RUN)
//   gap_count    out  [16]           saturating count of invalid RUN slots
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for lane 0 valid; ptr held at 0, other lanes ignored
// ST_RUN  | round-robin collection, one lane per cycle starting at ptr
// -----------------------------------------------------------------------------
module byte_un_striping_p #(
   parameter int LANES     = 2,
   parameter int WIDTH     = 32,
   parameter int GAP_LIMIT = 4
) (
   input  logic                       clk_nf,
   input  logic                       reset,
   input  logic [LANES-1:0]           valid_in,
   input  logic [LANES*WIDTH-1:0]     lane_in,
   output logic                       valid_out_c,
   output logic [WIDTH-1:0]           data_out_c,
   output logic [$clog2(LANES)-1:0]   lane_sel,
   output logic                       aligned,
   output logic [15:0]                gap_count
);

   localparam int PTR_W = $clog2(LANES);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANES - 1);
   localparam logic [3:0]       GAP_LIM  = 4'(GAP_LIMIT);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [3:0]        idle_rounds_q, idle_rounds_d;
   logic              round_hit_q, round_hit_d;
   logic              valid_q, valid_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [PTR_W-1:0]  sel_q, sel_d;
   logic              aligned_q, aligned_d;

   logic              cur_valid;
   logic [WIDTH-1:0]  cur_data;

   assign cur_valid = valid_in[ptr_q];
   assign cur_data  = lane_in[ptr_q*WIDTH +: WIDTH];

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      idle_rounds_d = idle_rounds_q;
      round_hit_d   = round_hit_q;
      valid_d       = 1'b0;
      data_d        = '0;
      sel_d         = '0;
      aligned_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ptr_d = '0;
            if (valid_in[0]) begin
               valid_d       = 1'b1;
               data_d        = lane_in[WIDTH-1:0];
               aligned_d     = 1'b1;
               ptr_d         = PTR_W'(1);
               idle_rounds_d = '0;
               // The entry slot is part of round 0, so that round is never empty.
               round_hit_d   = 1'b1;
               state_d       = ST_RUN;
            end
         end

         ST_RUN: begin
            valid_d   = cur_valid;
            data_d    = cur_valid ? cur_data : '0;
            sel_d     = ptr_q;
            aligned_d = 1'b1;
            if (cur_valid) begin
               round_hit_d = 1'b1;
            end
            if (ptr_q == PTR_LAST) begin
               ptr_d       = '0;
               round_hit_d = 1'b0;
               if (round_hit_q || cur_valid) begin
                  idle_rounds_d = '0;
               end else begin
                  idle_rounds_d = idle_rounds_q + 4'd1;
                  if (idle_rounds_d == GAP_LIM) begin
                     state_d   = ST_IDLE;
                     aligned_d = 1'b0;
                  end
               end
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_nf or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         idle_rounds_q <= '0;
         round_hit_q   <= 1'b0;
         valid_q       <= 1'b0;
         data_q        <= '0;
         sel_q         <= '0;
         aligned_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         idle_rounds_q <= idle_rounds_d;
         round_hit_q   <= round_hit_d;
         valid_q       <= valid_d;
         data_q        <= data_d;
         sel_q         <= sel_d;
         aligned_q     <= aligned_d;
      end
   end

   assign valid_out_c = valid_q;
   assign data_out_c  = data_q;
   assign lane_sel    = sel_q;
   assign aligned     = aligned_q;

`ifdef UNSTRIPE_GAP_CNT_EN
   logic [15:0] gap_q, gap_d;

   always_comb begin
      gap_d = gap_q;
      if ((state_q == ST_RUN) && !cur_valid && (gap_q != 16'hFFFF)) begin
         gap_d = gap_q + 16'd1;
      end
   end

   always_ff @(posedge clk_nf or negedge reset) begin
      if (!reset) begin
         gap_q <= '0;
      end else begin
         gap_q <= gap_d;
      end
   end

   assign gap_count = gap_q;
`else
   assign gap_count = 16'h0000;
`endif

endmodule
